// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO in front of the data memory store port.
// Retired stores are queued and drained one per cycle whenever the memory is
// not servicing a load. An empty buffer lets a store go straight to the m_*
// registers, so it reaches memory the cycle after it is accepted. The block
// also reports load/store word hazards and implements a fence (drain-all).
// Optional feature: define STORE_BUF_FWD_EN to forward a buffered word store
// to a load at the exact same address instead of raising l_conflict.

`ifndef ALU_SB
`define ALU_SB 6'd21
`endif
`ifndef ALU_SH
`define ALU_SH 6'd22
`endif
`ifndef ALU_SW
`define ALU_SW 6'd23
`endif

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [5:0]  s_alucode,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_data,
  output logic        s_misalign,
  input  logic        ld_busy,
  input  logic [31:0] l_addr,
  output logic        l_conflict,
  input  logic        fence_req,
  output logic        fence_done,
  output logic        m_en,
  output logic        m_is_store,
  output logic [5:0]  m_alucode,
  output logic [31:0] m_addr,
  output logic [31:0] m_data,
  output logic        l_fwd_valid,
  output logic [31:0] l_fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FENCE, S_DONE} state_t;
  state_t state_q, state_d;

  logic [5:0]       op_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic        m_en_q;
  logic [5:0]  m_alucode_q;
  logic [31:0] m_addr_q, m_data_q;
  logic        s_misalign_q;

  logic accept, misalign, buf_empty, pop, bypass, push;

  // No pass-through when full: a full buffer refuses even if it drains now.
  assign s_ready   = (count_q != CNT_W'(DEPTH)) && (state_q != S_FENCE);
  assign accept    = s_valid && s_ready;
  assign misalign  = ((s_alucode == `ALU_SW) && (s_addr[1:0] != 2'b00)) ||
                     ((s_alucode == `ALU_SH) && (s_addr[1:0] == 2'b11));
  assign buf_empty = (count_q == '0);
  assign pop       = !buf_empty && !ld_busy;
  // Empty buffer and idle memory: the new store skips the FIFO entirely.
  assign bypass    = accept && !misalign && buf_empty && !ld_busy;
  assign push      = accept && !misalign && !bypass;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  // FIFO storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[wr_ptr_q]   <= s_alucode;
      addr_q[wr_ptr_q] <= s_addr;
      data_q[wr_ptr_q] <= s_data;
    end
  end

  // Pointers, occupancy, memory-port registers and misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      m_en_q       <= 1'b0;
      m_alucode_q  <= '0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      s_misalign_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      m_en_q       <= pop || bypass;
      s_misalign_q <= accept && misalign;
      if (pop) begin
        m_alucode_q <= op_q[rd_ptr_q];
        m_addr_q    <= addr_q[rd_ptr_q];
        m_data_q    <= data_q[rd_ptr_q];
      end else if (bypass) begin
        m_alucode_q <= s_alucode;
        m_addr_q    <= s_addr;
        m_data_q    <= s_data;
      end
    end
  end

  assign m_en       = m_en_q;
  assign m_is_store = m_en_q;
  assign m_alucode  = m_alucode_q;
  assign m_addr     = m_addr_q;
  assign m_data     = m_data_q;
  assign s_misalign = s_misalign_q;

  // Fence state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Fence next-state. Enqueue is blocked in FENCE, so an empty FIFO there means
  // nothing follows the store currently on m_*, which lands at this edge.
  always_comb begin
    state_d    = state_q;
    fence_done = 1'b0;
    unique case (state_q)
      S_IDLE:  if (fence_req) state_d = S_FENCE;
      S_FENCE: if (buf_empty) state_d = S_DONE;
      S_DONE: begin
        fence_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic             hit_any;
  logic [PTR_W-1:0] idx;
`ifdef STORE_BUF_FWD_EN
  logic [5:0]       yng_op;
  logic [31:0]      yng_addr, yng_data;
`endif

  // Word-hazard scan: in-flight entry first, then FIFO oldest to youngest,
  // so the last hit seen is the youngest store to that word.
  always_comb begin
    hit_any = m_en_q && (m_addr_q[31:2] == l_addr[31:2]);
`ifdef STORE_BUF_FWD_EN
    yng_op   = m_alucode_q;
    yng_addr = m_addr_q;
    yng_data = m_data_q;
`endif
    idx = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx][31:2] == l_addr[31:2])) begin
        hit_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
        yng_op   = op_q[idx];
        yng_addr = addr_q[idx];
        yng_data = data_q[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic fwd_hit;
  // Only a full-word store at the exact load address can supply the load.
  assign fwd_hit     = hit_any && (yng_op == `ALU_SW) && (yng_addr == l_addr);
  assign l_fwd_valid = fwd_hit;
  assign l_fwd_data  = fwd_hit ? yng_data : '0;
  assign l_conflict  = hit_any && !fwd_hit;
`else
  logic unused_l_addr_lo;
  assign unused_l_addr_lo = ^l_addr[1:0];
  assign l_fwd_valid      = 1'b0;
  assign l_fwd_data       = '0;
  assign l_conflict       = hit_any;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.

`ifndef ALU_SB
`define ALU_SB 6'd21
`endif
`ifndef ALU_SH
`define ALU_SH 6'd22
`endif
`ifndef ALU_SW
`define ALU_SW 6'd23
`endif

module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, s_valid, ld_busy, fence_req;
  logic [5:0]  s_alucode;
  logic [31:0] s_addr, s_data, l_addr;
  logic        s_ready, s_misalign, l_conflict, fence_done;
  logic        m_en, m_is_store, l_fwd_valid;
  logic [5:0]  m_alucode;
  logic [31:0] m_addr, m_data, l_fwd_data;

  int n_cmp = 0;
  int n_bad = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_alucode(s_alucode), .s_addr(s_addr), .s_data(s_data),
    .s_misalign(s_misalign), .ld_busy(ld_busy), .l_addr(l_addr),
    .l_conflict(l_conflict), .fence_req(fence_req), .fence_done(fence_done),
    .m_en(m_en), .m_is_store(m_is_store), .m_alucode(m_alucode),
    .m_addr(m_addr), .m_data(m_data), .l_fwd_valid(l_fwd_valid),
    .l_fwd_data(l_fwd_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t mq[$];          // stores waiting in the buffer, oldest first
  st_t mdl_m;          // last store handed to memory
  bit  mdl_men;        // a store is being written this cycle
  bit  mdl_mis;
  int  mdl_phase;      // 0 normal, 1 fencing, 2 fence complete

  function automatic bit is_mis(input logic [5:0] op, input logic [31:0] a);
    return ((op == `ALU_SW) && (a[1:0] != 2'b00)) || ((op == `ALU_SH) && (a[1:0] == 2'b11));
  endfunction

  function automatic bit mdl_ready();
    return (mq.size() < DEPTH) && (mdl_phase != 1);
  endfunction

  task automatic mdl_lookup(output bit conf, output bit fv, output logic [31:0] fd);
    st_t all[$];
    st_t y;
    bit  hit;
    all = {};
    if (mdl_men) all.push_back(mdl_m);
    foreach (mq[i]) all.push_back(mq[i]);
    hit = 0;
    y   = '0;
    foreach (all[i]) if (all[i].addr[31:2] == l_addr[31:2]) begin hit = 1; y = all[i]; end
    fv   = FWD && hit && (y.op == `ALU_SW) && (y.addr == l_addr);
    conf = hit && !fv;
    fd   = fv ? y.data : 32'h0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit acc, mis, was_empty;
    acc = s_valid && mdl_ready();
    @(posedge clk);
    if (rst) begin
      mq.delete(); mdl_men = 0; mdl_m = '0; mdl_mis = 0; mdl_phase = 0;
    end else begin
      mis       = is_mis(s_alucode, s_addr);
      was_empty = (mq.size() == 0);
      case (mdl_phase)
        0: if (fence_req) mdl_phase = 1;
        1: if (was_empty) mdl_phase = 2;
        default: mdl_phase = 0;
      endcase
      if (acc && !mis) mq.push_back('{s_alucode, s_addr, s_data});
      mdl_men = 0;
      if (!ld_busy && mq.size() > 0) begin mdl_m = mq.pop_front(); mdl_men = 1; end
      mdl_mis = acc && mis;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_valid = 0; s_alucode = `ALU_SW; s_addr = 0; s_data = 0;
    ld_busy = 0; l_addr = 32'hFFFF_0000; fence_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    s_valid = 1; s_alucode = op; s_addr = a; s_data = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    #1;
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL reset_m_en got=%0h exp=0", m_en); end
    n_cmp++; if (m_is_store !== 1'b0) begin n_bad++; $display("FAIL reset_m_is_store got=%0h exp=0", m_is_store); end
    n_cmp++; if ({m_alucode, m_addr, m_data} !== 70'h0) begin n_bad++; $display("FAIL reset_m_fields got=%0h/%0h/%0h exp=0", m_alucode, m_addr, m_data); end
    n_cmp++; if (s_misalign !== 1'b0 || fence_done !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got=%0h/%0h exp=0/0", s_misalign, fence_done); end
    rst = 0;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got=%0h exp=1", s_ready); end
    n_cmp++; if (l_conflict !== 1'b0) begin n_bad++; $display("FAIL reset_l_conflict got=%0h exp=0", l_conflict); end
  endtask

  task automatic test_single();
    do_reset();
    put(`ALU_SW, 32'h100, 32'hDEADBEEF);
    tick(); s_valid = 0; #1;
    n_cmp++; if (m_en !== 1'b1 || m_is_store !== 1'b1) begin n_bad++; $display("FAIL single_m_en got=%0h/%0h exp=1/1", m_en, m_is_store); end
    n_cmp++; if (m_addr !== 32'h100) begin n_bad++; $display("FAIL single_m_addr got=%0h exp=100", m_addr); end
    n_cmp++; if (m_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_m_data got=%0h exp=deadbeef", m_data); end
    n_cmp++; if (m_alucode !== `ALU_SW) begin n_bad++; $display("FAIL single_m_alucode got=%0h exp=%0h", m_alucode, `ALU_SW); end
    tick(); #1;
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL single_m_en_drop got=%0h exp=0", m_en); end
    n_cmp++; if (m_addr !== 32'h100) begin n_bad++; $display("FAIL single_m_addr_hold got=%0h exp=100", m_addr); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    ld_busy = 1;
    for (int i = 0; i < 4; i++) begin
      put(`ALU_SW, 32'h40 + 4*i, 32'hA000_0000 + i);
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d got=%0h exp=1", i, s_ready); end
      tick();
    end
    put(`ALU_SW, 32'h50, 32'hBAD0BAD0);
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready got=%0h exp=0", s_ready); end
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL fill_no_drain got=%0h exp=0", m_en); end
    tick();
    s_valid = 0; ld_busy = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_cmp++; if (m_en !== 1'b1 || m_addr !== 32'h40 + 4*i || m_data !== 32'hA000_0000 + i)
        begin n_bad++; $display("FAIL drain_%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, m_en, m_addr, m_data, 32'h40 + 4*i, 32'hA000_0000 + i); end
      if (i == 0) begin
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got=%0h exp=1", s_ready); end
      end
    end
    tick(); #1;
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL drain_end got=%0h exp=0", m_en); end
  endtask

  task automatic test_misalign();
    do_reset();
    put(`ALU_SH, 32'h103, 32'h1111);
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL mis_sh_ready got=%0h exp=1", s_ready); end
    tick(); s_valid = 0; #1;
    n_cmp++; if (m_en !== 1'b0 || s_misalign !== 1'b1) begin n_bad++; $display("FAIL mis_sh got=%0h/%0h exp=0/1", m_en, s_misalign); end
    tick(); #1;
    n_cmp++; if (s_misalign !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got=%0h exp=0", s_misalign); end
    put(`ALU_SW, 32'h102, 32'h2222);
    tick(); s_valid = 0; #1;
    n_cmp++; if (m_en !== 1'b0 || s_misalign !== 1'b1) begin n_bad++; $display("FAIL mis_sw got=%0h/%0h exp=0/1", m_en, s_misalign); end
    put(`ALU_SH, 32'h102, 32'h3333);
    tick(); s_valid = 0; #1;
    n_cmp++; if (m_en !== 1'b1 || m_addr !== 32'h102 || s_misalign !== 1'b0)
      begin n_bad++; $display("FAIL mis_sh_ok got=%0h/%0h/%0h exp=1/102/0", m_en, m_addr, s_misalign); end
  endtask

  task automatic test_conflict();
    do_reset();
    ld_busy = 1;
    put(`ALU_SB, 32'h200, 32'hAB);
    tick(); s_valid = 0;
    l_addr = 32'h203; #1;
    n_cmp++; if (l_conflict !== 1'b1 || l_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL conf_203 got=%0h/%0h exp=1/0", l_conflict, l_fwd_valid); end
    l_addr = 32'h204; #1;
    n_cmp++; if (l_conflict !== 1'b0) begin n_bad++; $display("FAIL conf_204 got=%0h exp=0", l_conflict); end
    ld_busy = 0; l_addr = 32'h200;
    tick(); #1;
    n_cmp++; if (m_en !== 1'b1 || l_conflict !== 1'b1) begin n_bad++; $display("FAIL conf_inflight got=%0h/%0h exp=1/1", m_en, l_conflict); end
    tick(); #1;
    n_cmp++; if (l_conflict !== 1'b0) begin n_bad++; $display("FAIL conf_gone got=%0h exp=0", l_conflict); end
  endtask

  task automatic test_fence();
    int npulse, last_en, done_at, cyc;
    bit ready_bad;
    do_reset();
    ld_busy = 1;
    for (int i = 0; i < 3; i++) begin put(`ALU_SW, 32'h80 + 4*i, i); tick(); end
    s_valid = 0; ld_busy = 0; fence_req = 1;
    tick();
    fence_req = 0;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL fence_ready got=%0h exp=0", s_ready); end
    npulse = 0; last_en = -1; done_at = -1; cyc = 0; ready_bad = 0;
    while (cyc < 20 && done_at < 0) begin
      if (m_en === 1'b1) begin npulse++; last_en = cyc; end
      if (fence_done === 1'b1) done_at = cyc;
      else if (s_ready !== 1'b0) ready_bad = 1;
      tick(); #1; cyc++;
    end
    n_cmp++; if (done_at < 0) begin n_bad++; $display("FAIL fence_timeout got=none exp=fence_done within 20 cycles"); end
    n_cmp++; if (npulse != 3) begin n_bad++; $display("FAIL fence_drains got=%0d exp=3", npulse); end
    n_cmp++; if (done_at != last_en + 1) begin n_bad++; $display("FAIL fence_done_timing got=%0d exp=%0d", done_at, last_en + 1); end
    n_cmp++; if (ready_bad) begin n_bad++; $display("FAIL fence_ready_hold got=1 exp=0 during fence"); end
    n_cmp++; if (fence_done !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL fence_after got=%0h/%0h exp=0/1", fence_done, s_ready); end
  endtask

  task automatic test_fwd();
    do_reset();
    ld_busy = 1;
    put(`ALU_SW, 32'h300, 32'h12345678);
    tick(); s_valid = 0;
    l_addr = 32'h300; #1;
    n_cmp++; if (l_fwd_valid !== FWD || l_conflict !== !FWD) begin n_bad++; $display("FAIL fwd_sw got=%0h/%0h exp=%0h/%0h", l_fwd_valid, l_conflict, FWD, !FWD); end
    n_cmp++; if (l_fwd_data !== (FWD ? 32'h12345678 : 32'h0)) begin n_bad++; $display("FAIL fwd_data got=%0h exp=%0h", l_fwd_data, FWD ? 32'h12345678 : 32'h0); end
    l_addr = 32'h302; #1;
    n_cmp++; if (l_fwd_valid !== 1'b0 || l_conflict !== 1'b1) begin n_bad++; $display("FAIL fwd_offset got=%0h/%0h exp=0/1", l_fwd_valid, l_conflict); end
    put(`ALU_SB, 32'h301, 32'h99);
    tick(); s_valid = 0; l_addr = 32'h300; #1;
    n_cmp++; if (l_fwd_valid !== 1'b0 || l_conflict !== 1'b1) begin n_bad++; $display("FAIL fwd_younger_sb got=%0h/%0h exp=0/1", l_fwd_valid, l_conflict); end
    put(`ALU_SW, 32'h300, 32'hCAFEF00D);
    tick(); s_valid = 0; #1;
    n_cmp++; if (l_fwd_data !== (FWD ? 32'hCAFEF00D : 32'h0) || l_conflict !== !FWD)
      begin n_bad++; $display("FAIL fwd_youngest got=%0h/%0h exp=%0h/%0h", l_fwd_data, l_conflict, FWD ? 32'hCAFEF00D : 32'h0, !FWD); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ld_busy = 1;
    for (int i = 0; i < 3; i++) begin put(`ALU_SW, 32'hC0 + 4*i, i); tick(); end
    s_valid = 0; ld_busy = 0; rst = 1;
    tick(); #1;
    n_cmp++; if (m_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_m_en got=%0h exp=0", m_en); end
    rst = 0;
    tick(); #1;
    n_cmp++; if (m_en !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_after got=%0h/%0h exp=0/1", m_en, s_ready); end
  endtask

  task automatic test_random();
    bit exp_conf, exp_fv;
    logic [31:0] exp_fd;
    logic [5:0] ops [3];
    ops[0] = `ALU_SB; ops[1] = `ALU_SH; ops[2] = `ALU_SW;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s_valid   = ($urandom_range(0, 2) != 0);
      s_alucode = ops[$urandom_range(0, 2)];
      s_addr    = 32'h400 + 4*$urandom_range(0, 7) + (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
      s_data    = $urandom;
      ld_busy   = ($urandom_range(0, 3) == 0);
      l_addr    = 32'h400 + $urandom_range(0, 31);
      fence_req = ($urandom_range(0, 24) == 0);
      #1;
      mdl_lookup(exp_conf, exp_fv, exp_fd);
      n_cmp++; if (s_ready !== mdl_ready()) begin n_bad++; $display("FAIL rnd_s_ready c=%0d got=%0h exp=%0h", c, s_ready, mdl_ready()); end
      n_cmp++; if (m_en !== mdl_men || m_is_store !== mdl_men) begin n_bad++; $display("FAIL rnd_m_en c=%0d got=%0h/%0h exp=%0h", c, m_en, m_is_store, mdl_men); end
      n_cmp++; if ({m_alucode, m_addr, m_data} !== mdl_m) begin n_bad++; $display("FAIL rnd_m_fields c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, m_alucode, m_addr, m_data, mdl_m.op, mdl_m.addr, mdl_m.data); end
      n_cmp++; if (s_misalign !== mdl_mis) begin n_bad++; $display("FAIL rnd_misalign c=%0d got=%0h exp=%0h", c, s_misalign, mdl_mis); end
      n_cmp++; if (fence_done !== (mdl_phase == 2)) begin n_bad++; $display("FAIL rnd_fence_done c=%0d got=%0h exp=%0h", c, fence_done, mdl_phase == 2); end
      n_cmp++; if (l_conflict !== exp_conf) begin n_bad++; $display("FAIL rnd_conflict c=%0d got=%0h exp=%0h", c, l_conflict, exp_conf); end
      n_cmp++; if (l_fwd_valid !== exp_fv || l_fwd_data !== exp_fd) begin n_bad++; $display("FAIL rnd_fwd c=%0d got=%0h/%0h exp=%0h/%0h", c, l_fwd_valid, l_fwd_data, exp_fv, exp_fd); end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    mdl_m = '0; mdl_men = 0; mdl_mis = 0; mdl_phase = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_drain();
    test_misalign();
    test_conflict();
    test_fence();
    test_fwd();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
